ibex_fetch_aligner: RTL and testbench

IBEX_FETCH_ALIGNER -- requirements
Module: ibex_fetch_aligner

---
 rtl/ibex_fetch_aligner_if.sv | 42 ++++
 rtl/ibex_fetch_aligner.sv | 167 ++++++++++++++++
 tb/tb_ibex_fetch_aligner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_fetch_aligner_if.sv
// rtl/ibex_fetch_aligner_if.sv - fetch-side and decoder-side handshake bundle of the fetch aligner
//
// Purpose: groups the fetch word stream, the branch redirect and the aligned
// instruction stream into one bundle.
// Ports (signals):
//   fetch_valid_i/fetch_ready_o       fetch word handshake
//   fetch_rdata_i, fetch_addr_i       fetched word and its word address
//   fetch_err_i                       bus error attached to the fetch word
//   branch_i, branch_addr_i           redirect and target (bit 1 used)
//   out_valid_o/out_ready_i           aligned instruction handshake
//   out_instr_o, out_addr_o           aligned instruction and byte address
//   out_compressed_o, out_err_o       instruction attributes
// Modports: slave = the aligner, master = the fetch unit / decoder side.
interface ibex_fetch_aligner_if;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_err_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_compressed_o;
  logic        out_err_o;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i,
    input  branch_i, branch_addr_i, out_ready_i,
    output fetch_ready_o, out_valid_o, out_instr_o, out_addr_o,
    output out_compressed_o, out_err_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i,
    output branch_i, branch_addr_i, out_ready_i,
    input  fetch_ready_o, out_valid_o, out_instr_o, out_addr_o,
    input  out_compressed_o, out_err_o
  );
endinterface

// File: rtl/ibex_fetch_aligner.sv
// rtl/ibex_fetch_aligner.sv - realigns 32-bit fetch words into 16/32-bit RISC-V instructions
//
// Purpose: turns a stream of word-aligned fetch words into a stream of
// instructions that may start on any halfword boundary. A single halfword
// of an instruction straddling two words is parked in a hold register.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset, takes priority over branch
//   bus    ibex_fetch_aligner_if.slave (fetch stream, redirect, aligned output)
// Outputs are combinational from state and fetch inputs (zero latency).
module ibex_fetch_aligner (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibex_fetch_aligner_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } mode_e;

  mode_e       mode_q, mode_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic        hold_err_q, hold_err_d;
  logic        skip_lo_q, skip_lo_d;

  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        fetch_ready;

  logic [31:0] word_addr;
  logic [31:0] upper_addr;
  logic [15:0] rdata_lo;
  logic [15:0] rdata_hi;
  logic        unused_bits;

  assign word_addr  = {bus.fetch_addr_i[31:2], 2'b00};
  assign upper_addr = word_addr + 32'd2;
  assign rdata_lo   = bus.fetch_rdata_i[15:0];
  assign rdata_hi   = bus.fetch_rdata_i[31:16];

  assign unused_bits = ^{bus.branch_addr_i[31:2], bus.branch_addr_i[0], bus.fetch_addr_i[1:0]};

  always_comb begin
    out_valid   = 1'b0;
    out_instr   = 32'd0;
    out_addr    = 32'd0;
    out_err     = 1'b0;
    fetch_ready = 1'b0;
    mode_d      = mode_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    hold_err_d  = hold_err_q;
    skip_lo_d   = skip_lo_q;

    if (bus.branch_i) begin
      // Redirect wins over any concurrent handshake on either side.
      mode_d      = EMPTY;
      hold_data_d = 16'd0;
      hold_addr_d = 32'd0;
      hold_err_d  = 1'b0;
      skip_lo_d   = bus.branch_addr_i[1];
    end else begin
      unique case (mode_q)
        HALF: begin
          if (hold_err_q) begin
            // A faulted halfword is emitted alone; never glue it to the next word.
            out_valid = 1'b1;
            out_instr = {16'd0, hold_data_q};
            out_addr  = hold_addr_q;
            out_err   = 1'b1;
            if (bus.out_ready_i) mode_d = EMPTY;
          end else if (hold_data_q[1:0] != 2'b11) begin
            out_valid = 1'b1;
            out_instr = {16'd0, hold_data_q};
            out_addr  = hold_addr_q;
            if (bus.out_ready_i) mode_d = EMPTY;
          end else begin
            // Straddling 32-bit instruction: held low half plus low half of the word.
            out_valid   = bus.fetch_valid_i;
            out_instr   = bus.fetch_valid_i ? {rdata_lo, hold_data_q} : 32'd0;
            out_addr    = bus.fetch_valid_i ? hold_addr_q : 32'd0;
            out_err     = bus.fetch_valid_i & bus.fetch_err_i;
            fetch_ready = bus.fetch_valid_i & bus.out_ready_i;
            if (fetch_ready) begin
              hold_data_d = rdata_hi;
              hold_addr_d = upper_addr;
              hold_err_d  = bus.fetch_err_i;
            end
          end
        end
        default: begin
          if (bus.fetch_valid_i) begin
            if (skip_lo_q) begin
              if (rdata_hi[1:0] != 2'b11) begin
                out_valid   = 1'b1;
                out_instr   = {16'd0, rdata_hi};
                out_addr    = upper_addr;
                out_err     = bus.fetch_err_i;
                fetch_ready = bus.out_ready_i;
                if (bus.out_ready_i) skip_lo_d = 1'b0;
              end else begin
                // Branch target is the low half of a 32-bit instruction: park it.
                fetch_ready = 1'b1;
                hold_data_d = rdata_hi;
                hold_addr_d = upper_addr;
                hold_err_d  = bus.fetch_err_i;
                skip_lo_d   = 1'b0;
                mode_d      = HALF;
              end
            end else if (bus.fetch_err_i) begin
              // Faulted word is handed on whole; its upper half is dropped.
              out_valid   = 1'b1;
              out_instr   = bus.fetch_rdata_i;
              out_addr    = word_addr;
              out_err     = 1'b1;
              fetch_ready = bus.out_ready_i;
            end else if (rdata_lo[1:0] != 2'b11) begin
              out_valid   = 1'b1;
              out_instr   = {16'd0, rdata_lo};
              out_addr    = word_addr;
              fetch_ready = bus.out_ready_i;
              if (bus.out_ready_i) begin
                hold_data_d = rdata_hi;
                hold_addr_d = upper_addr;
                hold_err_d  = 1'b0;
                mode_d      = HALF;
              end
            end else begin
              out_valid   = 1'b1;
              out_instr   = bus.fetch_rdata_i;
              out_addr    = word_addr;
              fetch_ready = bus.out_ready_i;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q      <= EMPTY;
      hold_data_q <= 16'd0;
      hold_addr_q <= 32'd0;
      hold_err_q  <= 1'b0;
      skip_lo_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      hold_err_q  <= hold_err_d;
      skip_lo_q   <= skip_lo_d;
    end
  end

  assign bus.out_valid_o      = out_valid;
  assign bus.out_instr_o      = out_instr;
  assign bus.out_addr_o       = out_addr;
  assign bus.out_err_o        = out_err;
  assign bus.out_compressed_o = out_valid & (out_instr[1:0] != 2'b11);
  assign bus.fetch_ready_o    = fetch_ready;

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// tb/tb_ibex_fetch_aligner.sv - self-checking bench for ibex_fetch_aligner
module tb_ibex_fetch_aligner;

  typedef struct {
    logic [15:0] d;
    logic [31:0] a;
    logic        e;
    logic        w;
  } parcel_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_fetch_aligner_if bus ();

  ibex_fetch_aligner dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a queue of pending halfword parcels plus a skip flag.
  parcel_t     q[$];
  parcel_t     view[$];
  logic        skip_m = 1'b0;
  logic        exp_valid, exp_comp, exp_err, exp_fready;
  logic [31:0] exp_instr, exp_addr;
  int          take;
  bit          whole, park, word_used;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    parcel_t p, p0, p1;
    logic [31:0] fa;
    view = q;
    exp_valid = 0; exp_instr = 0; exp_addr = 0; exp_err = 0; exp_comp = 0; exp_fready = 0;
    take = 0; whole = 0; park = 0; word_used = 0;
    if (bus.branch_i) return;
    if (bus.fetch_valid_i) begin
      fa = bus.fetch_addr_i & 32'hFFFF_FFFC;
      if (!skip_m) begin
        p.d = bus.fetch_rdata_i[15:0]; p.a = fa; p.e = bus.fetch_err_i; p.w = 1'b1;
        view.push_back(p);
      end
      p.d = bus.fetch_rdata_i[31:16]; p.a = fa + 32'd2; p.e = bus.fetch_err_i; p.w = 1'b1;
      view.push_back(p);
    end
    if (view.size() == 0) return;
    p0 = view[0];
    if (p0.e && p0.w && !skip_m) begin
      whole = 1; exp_valid = 1; exp_instr = bus.fetch_rdata_i; exp_addr = p0.a; exp_err = 1;
    end else if (p0.d[1:0] != 2'b11 || (p0.e && !p0.w)) begin
      exp_valid = 1; exp_instr = {16'h0, p0.d}; exp_addr = p0.a; exp_err = p0.e; take = 1;
    end else if (view.size() >= 2) begin
      p1 = view[1];
      exp_valid = 1; exp_instr = {p1.d, p0.d}; exp_addr = p0.a; exp_err = p0.e | p1.e; take = 2;
    end else if (p0.w) begin
      park = 1;
    end
    exp_comp = exp_valid && (exp_instr[1:0] != 2'b11);
    word_used = whole || park || (take >= 1 && view[0].w) || (take == 2 && view[1].w);
    exp_fready = word_used && (park || bus.out_ready_i);
  endtask

  task automatic model_update();
    parcel_t p;
    int n;
    bit fire;
    if (rst) begin
      q.delete(); skip_m = 1'b0;
    end else if (bus.branch_i) begin
      q.delete(); skip_m = bus.branch_addr_i[1];
    end else begin
      fire = exp_valid && bus.out_ready_i;
      n = 0;
      if (!park && fire) n = whole ? view.size() : take;
      if (fire || park) begin
        q.delete();
        for (int i = n; i < view.size(); i++) begin
          p = view[i];
          if (!p.w || word_used) begin
            p.w = 1'b0;
            q.push_back(p);
          end
        end
        if (word_used) skip_m = 1'b0;
      end
    end
  endtask

  task automatic eval_check();
    #1;
    model_eval();
    chk("out_valid", {31'd0, bus.out_valid_o}, {31'd0, exp_valid});
    chk("out_instr", bus.out_instr_o, exp_instr);
    chk("out_addr", bus.out_addr_o, exp_addr);
    chk("out_compressed", {31'd0, bus.out_compressed_o}, {31'd0, exp_comp});
    chk("out_err", {31'd0, bus.out_err_o}, {31'd0, exp_err});
    chk("fetch_ready", {31'd0, bus.fetch_ready_o}, {31'd0, exp_fready});
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Directed expectations written straight from the instruction streams.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] addr, input logic comp, input logic err,
                            input logic fr);
    chk({tag, ".valid"}, {31'd0, bus.out_valid_o}, {31'd0, v});
    chk({tag, ".instr"}, bus.out_instr_o, instr);
    chk({tag, ".addr"}, bus.out_addr_o, addr);
    chk({tag, ".comp"}, {31'd0, bus.out_compressed_o}, {31'd0, comp});
    chk({tag, ".err"}, {31'd0, bus.out_err_o}, {31'd0, err});
    chk({tag, ".fready"}, {31'd0, bus.fetch_ready_o}, {31'd0, fr});
  endtask

  task automatic fetch(input logic v, input logic [31:0] d, input logic [31:0] a, input logic e);
    bus.fetch_valid_i = v;
    bus.fetch_rdata_i = d;
    bus.fetch_addr_i  = a;
    bus.fetch_err_i   = e;
  endtask

  task automatic do_branch(input logic [31:0] target);
    bus.branch_i = 1'b1; bus.branch_addr_i = target;
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    eval_check();
    expect_out("branch", 0, 32'd0, 32'd0, 0, 0, 0);
    advance();
    bus.branch_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    r = $urandom & 32'h0000_0FFE;
    if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000E);
    return r;
  endfunction

  logic [31:0] pc, cur_data;
  logic [1:0]  cur_lo;
  logic        cur_err, have_word, consumed;

  initial begin
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    bus.branch_i = 1'b0; bus.branch_addr_i = 32'd0; bus.out_ready_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Held in reset with no fetch: everything idle.
    eval_check();
    expect_out("reset", 0, 32'd0, 32'd0, 0, 0, 0);
    advance();
    rst = 1'b0;

    // c.li followed by c.nop in one word.
    fetch(1'b1, 32'h0001_4501, 32'h0000_0100, 1'b0);
    eval_check(); expect_out("cli", 1, 32'h0000_4501, 32'h100, 1, 0, 1); advance();
    fetch(1'b1, 32'hDEAD_BEEF, 32'h0000_0104, 1'b0);
    eval_check(); expect_out("cnop", 1, 32'h0000_0001, 32'h102, 1, 0, 0); advance();
    do_branch(32'h0000_0200);

    // Straddling 32-bit instruction, with a stall then a branch on the third stall cycle.
    fetch(1'b1, 32'h0513_4501, 32'h0000_0200, 1'b0);
    eval_check(); expect_out("s_c", 1, 32'h0000_4501, 32'h200, 1, 0, 1); advance();
    fetch(1'b1, 32'h0000_0015, 32'h0000_0204, 1'b0);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      eval_check(); expect_out("stall", 1, 32'h0015_0513, 32'h202, 0, 0, 0); advance();
    end
    bus.branch_i = 1'b1; bus.branch_addr_i = 32'h0000_0200;
    eval_check(); expect_out("stall_br", 0, 32'd0, 32'd0, 0, 0, 0); advance();
    bus.branch_i = 1'b0; bus.out_ready_i = 1'b1;
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    eval_check(); expect_out("post_br", 0, 32'd0, 32'd0, 0, 0, 0); advance();

    fetch(1'b1, 32'h0513_4501, 32'h0000_0200, 1'b0);
    eval_check(); advance();
    fetch(1'b1, 32'h0000_0015, 32'h0000_0204, 1'b0);
    eval_check(); expect_out("s_32", 1, 32'h0015_0513, 32'h202, 0, 0, 1); advance();
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    eval_check(); expect_out("s_hold", 1, 32'h0000_0000, 32'h206, 1, 0, 0); advance();

    // Branch into the upper halfword.
    do_branch(32'h0000_0302);
    fetch(1'b1, 32'h4505_0000, 32'h0000_0300, 1'b0);
    eval_check(); expect_out("skip", 1, 32'h0000_4505, 32'h302, 1, 0, 1); advance();
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    eval_check(); expect_out("skip_end", 0, 32'd0, 32'd0, 0, 0, 0); advance();

    // Error on the word completing a straddling instruction, then reset mid-HALF.
    do_branch(32'h0000_0404);
    fetch(1'b1, 32'h0513_4501, 32'h0000_0404, 1'b0);
    eval_check(); advance();
    fetch(1'b1, 32'h0000_0015, 32'h0000_0408, 1'b1);
    eval_check(); expect_out("err32", 1, 32'h0015_0513, 32'h406, 0, 1, 1); advance();
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    eval_check(); expect_out("held_err", 1, 32'h0000_0000, 32'h40A, 1, 1, 0); advance();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      eval_check(); expect_out("rst_half", 0, 32'd0, 32'd0, 0, 0, 0); advance();
    end

    // Address wrap, with junk in the ignored low address bits.
    do_branch(32'hFFFF_FFFC);
    fetch(1'b1, 32'hFFFF_0001, 32'hFFFF_FFFE, 1'b0);
    eval_check(); expect_out("wrap_c", 1, 32'h0000_0001, 32'hFFFF_FFFC, 1, 0, 1); advance();
    fetch(1'b1, 32'h0001_0003, 32'h0000_0003, 1'b0);
    eval_check(); expect_out("wrap_32", 1, 32'h0003_FFFF, 32'hFFFF_FFFE, 0, 0, 1); advance();
    fetch(1'b0, 32'd0, 32'd0, 1'b0);
    eval_check(); expect_out("wrap_hi", 1, 32'h0000_0001, 32'h0000_0002, 1, 0, 0); advance();

    // Randomized traffic against the parcel-queue model.
    pc = 32'h0000_0000; have_word = 1'b0; cur_data = 32'd0; cur_lo = 2'd0; cur_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.branch_i = ($urandom_range(0, 31) == 0);
      bus.branch_addr_i = pick_addr();
      if (!have_word && $urandom_range(0, 3) != 0) begin
        have_word = 1'b1;
        cur_data = $urandom;
        cur_lo = 2'($urandom_range(0, 3));
        cur_err = ($urandom_range(0, 15) == 0);
      end
      fetch(have_word, cur_data, pc | {30'd0, cur_lo}, cur_err);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      eval_check();
      consumed = bus.fetch_valid_i && exp_fready;
      advance();
      if (rst) begin
        have_word = 1'b0; pc = pick_addr() & 32'hFFFF_FFFC;
      end else if (bus.branch_i) begin
        have_word = 1'b0; pc = bus.branch_addr_i & 32'hFFFF_FFFC;
      end else if (consumed) begin
        have_word = 1'b0; pc = pc + 32'd4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
